// File: rtl/cmp_pkg.sv
// Shared constants, output-stage encoding and round-robin helper for cmp_arbiter.
package cmp_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/cmp_arbiter_comparator.sv
// Unsigned magnitude comparator over one operand pair.
module Comparator_6bits
  import cmp_pkg::*;
(
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  output logic            AltB,
  output logic            AeqB,
  output logic            AgtB
);

  assign AltB = (A < B);
  assign AeqB = (A == B);
  assign AgtB = (A > B);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator among NREQ requesters, with a
// one-deep registered result stage under rsp_ready backpressure.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_lt,
  output logic                 rsp_eq,
  output logic                 rsp_gt,
  output logic [CNTW-1:0]      cmp_count
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : gBadNreq
    $error("cmp_arbiter: NREQ must be within 2..8");
  end
  if (IDW < IW) begin : gBadIdw
    $error("cmp_arbiter: IDW too narrow for NREQ");
  end

  logic [0:0]      state;
  logic [0:0]      stateNext;
  logic [IDW-1:0]  ptr;
  logic            canIssue_c;
  logic            grant_c;
  logic            grantFound;
  int unsigned     grantIdx;
  logic [OP_W-1:0] opA_c;
  logic [OP_W-1:0] opB_c;
  logic            cmpLt;
  logic            cmpEq;
  logic            cmpGt;

  assign canIssue_c = (state == ST_EMPTY) | rsp_ready;
  assign grant_c    = grantFound & canIssue_c & ~reset;
  assign rsp_valid  = (state == ST_FULL);

  // Rotate-priority scan: first valid requester at or after ptr.
  always_comb begin : pScan
    int unsigned cand;
    cand       = 32'd0;
    grantFound = 1'b0;
    grantIdx   = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grantFound && req_valid[IW'(cand)]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Operand mux feeding the shared comparator.
  always_comb begin : pOpMux
    opA_c = '0;
    opB_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i == grantIdx) begin
        opA_c = req_a[i*OP_W +: OP_W];
        opB_c = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin : pReady
    req_ready = '0;
    if (grant_c) req_ready[IW'(grantIdx)] = 1'b1;
  end

  Comparator_6bits uCmp (
    .A    (opA_c),
    .B    (opB_c),
    .AltB (cmpLt),
    .AeqB (cmpEq),
    .AgtB (cmpGt)
  );

  always_comb begin : pNext
    stateNext = state;
    case (state)
      ST_EMPTY: if (grant_c) stateNext = ST_FULL;
      ST_FULL:  if (!grant_c && rsp_ready) stateNext = ST_EMPTY;
      default:  stateNext = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin : pState
    if (reset) state <= ST_EMPTY;
    else       state <= stateNext;
  end

  // Result capture, pointer advance and saturating completion count.
  always_ff @(posedge clk) begin : pData
    if (reset) begin
      ptr       <= '0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
      cmp_count <= '0;
    end else begin
      if (grant_c) begin
        ptr    <= IDW'(rrNext(grantIdx, NREQ));
        rsp_id <= IDW'(grantIdx);
        rsp_lt <= cmpLt;
        rsp_eq <= cmpEq;
        rsp_gt <= cmpGt;
      end
      if (rsp_valid && rsp_ready && !(&cmp_count)) begin
        cmp_count <= cmp_count + CNTW'(1);
      end
    end
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter that shares one 6-bit magnitude comparator among NREQ requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester per cycle, registers the lt/eq/gt result together with the requester id, and holds it in a one-deep output stage under rsp_ready backpressure. It sits between the client blocks and the single comparator instance, so that instance never has to be replicated per client.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: id width; must be at least clog2(NREQ).
- CNTW, 16: width of the completed-compare counter.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising clk edge.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  6*NREQ  operand A; requester i owns bits [6i+5:6i].
- req_b  in  6*NREQ  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot or zero; bit i set means requester i is granted this cycle.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result this cycle.
- rsp_id  out  IDW  requester index that owns the result.
- rsp_lt, rsp_eq, rsp_gt  out  1 each  unsigned compare of A against B; exactly one is set while rsp_valid=1.
- cmp_count  out  CNTW  number of completed responses; saturates at all-ones.

## Operation
- Output stage FSM, two states:
  - EMPTY: entered on reset; rsp_valid=0.
  - FULL: rsp_valid=1.
- Transitions:
  - EMPTY → FULL on any grant.
  - FULL → EMPTY when rsp_ready=1 and there is no grant.
  - FULL stays FULL when rsp_ready=0.
  - FULL stays FULL when rsp_ready=1 and a grant occurs in the same cycle (back-to-back, zero bubble).
- Grant enable is `can_issue = (state==EMPTY) | rsp_ready`. When can_issue=0, req_ready is all zero.
- Arbitration: round-robin over the bits of req_valid, starting at pointer ptr and scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready is combinational from req_valid, ptr and can_issue.
  - A requester must not depend on req_ready to assert req_valid.
- On a grant to requester g:
  - The muxed operands drive the comparator.
  - The comparator outputs plus g are captured into the rsp_* registers.
  - ptr becomes (g+1) mod NREQ.
- With no grant, ptr holds.
- Requesters hold valid and operands stable until granted. Deasserting req_valid before a grant is allowed; the withdrawn request is simply skipped.
- Compare is unsigned 6-bit. 0 vs 63 gives lt. 63 vs 63 gives eq.
- cmp_count increments on each cycle where rsp_valid & rsp_ready, and holds at 2^CNTW−1.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_lt=rsp_eq=rsp_gt=0.
  - cmp_count=0, ptr=0, state=EMPTY.
  - req_ready=0 during the reset cycle.
- Reset mid-operation discards any held result and returns the arbiter to priority starting at requester 0. No response is emitted for the discarded result.

## Timing
- Latency: a grant in cycle t produces rsp_valid=1 with its result in cycle t+1.
- Throughput: one compare per cycle while rsp_ready=1 is held.
- A held result stays stable (id and flags) until the cycle in which it is accepted.
- Simultaneous accept and new grant: the new result replaces the old one at the edge. No cycle passes with rsp_valid=0.
- Simultaneous requests from all NREQ requesters are served in rotation. Every requester is granted within NREQ issue cycles.
- Invalid parameter settings (NREQ outside 2..8, or IDW < clog2(NREQ)) must trigger an elaboration-time error.

## Structure
- Package cmp_pkg holds:
  - the OP_W=6 constant;
  - the output-state encoding (ST_EMPTY=0, ST_FULL=1);
  - a function that returns the round-robin next index.
- One sub-module instance: the existing 6-bit magnitude comparator Comparator_6bits, driven by the granted operand mux. Its AltB/AeqB/AgtB outputs feed rsp_lt/eq/gt.
- The rotate-priority encoder stays inline; it is small and parameterized by NREQ.

## Test plan
- Reset and idle: assert reset for 2 cycles with all req_valid=1. Required: req_ready=0 and rsp_valid=0 during reset. After release, requester 0 is granted first, and cmp_count=0.
- Single compares:
  - Req 2 with A=5, B=9 → next cycle rsp_valid=1, rsp_id=2, lt=1.
  - A=63, B=63 → eq=1.
  - A=40, B=0 → gt=1.
- Fairness: all 4 requesters valid continuously with rsp_ready=1. Required: grants 0,1,2,3,0,1…, one per cycle, and cmp_count=8 after 8 accepted results.
- Backpressure: a result is held with rsp_ready=0 for 5 cycles. Required: req_ready=0 throughout, and rsp fields stable. When rsp_ready rises, a grant issues in the same cycle and the new result appears the next cycle with no gap.
- Mid-operation reset: assert reset while FULL with a pending result for id 3. Required: the next cycle shows rsp_valid=0, cmp_count=0 and ptr=0; after release, requester 0 is granted first.
- Saturation: with CNTW=4, complete 20 responses. Required: cmp_count stops at 15.
